gpu_fill_engine: RTL and testbench



---
 rtl/gpu_pkg.sv | 34 +++
 rtl/gpu_fill_addr_gen.sv | 51 +++++
 rtl/gpu_fill_engine.sv | 156 +++++++++++++++
 tb/tb_gpu_fill_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared constants for the framebuffer rectangle fill engine: geometry,
// register map, control/status bit positions and FSM state encoding.
package gpu_pkg;

  localparam int ROW_WORDS = 25;
  localparam int ROWS      = 600;

  localparam logic [23:0] REG_BASE = 24'h50010;

  localparam logic [1:0] REG_POS     = 2'd0;
  localparam logic [1:0] REG_SIZE    = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_INV_BIT   = 1;
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_ERR_BIT   = 1;

  localparam logic [13:0] ROW_WORDS_W = 14'(ROW_WORDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  // y*25 built from shifts so no multiplier is inferred.
  function automatic logic [13:0] row_base_of(input logic [9:0] y);
    logic [13:0] ye;
    ye = {4'b0, y};
    return (ye << 4) + (ye << 3) + ye;
  endfunction

endpackage

// File: rtl/gpu_fill_addr_gen.sv
// Row/column walker for a fill: keeps the running scanline base so the word
// index is base + x + col, and flags the final word of the rectangle.
module gpu_fill_addr_gen
  import gpu_pkg::*;
(
  input  logic        clk_bus,
  input  logic        rst,
  input  logic        start,
  input  logic        advance,
  input  logic [4:0]  x,
  input  logic [9:0]  y,
  input  logic [5:0]  w,
  input  logic [9:0]  h,
  output logic [13:0] word_index,
  output logic        last,
  output logic        row_odd
);

  logic [5:0]  col;
  logic [9:0]  row;
  logic [13:0] row_base;
  logic        col_last;
  logic        row_last;

  assign col_last   = (col == w - 6'd1);
  assign row_last   = (row == h - 10'd1);
  assign last       = col_last && row_last;
  assign word_index = row_base + {9'b0, x} + {8'b0, col};
  assign row_odd    = y[0] ^ row[0];

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (start) begin
      col      <= '0;
      row      <= '0;
      row_base <= row_base_of(y);
    end else if (advance) begin
      if (col_last) begin
        col      <= '0;
        row      <= row + 10'd1;
        row_base <= row_base + ROW_WORDS_W;
      end else begin
        col <= col + 6'd1;
      end
    end
  end

endmodule

// File: rtl/gpu_fill_engine.sv
// Bus-side rectangle fill engine: passes CPU writes to the framebuffer when
// idle, streams a pattern into a rectangle on command. Option: FILL_ROWINV_EN.
module gpu_fill_engine
  import gpu_pkg::*;
(
  input  logic        clk_bus,
  input  logic        rst,
  input  logic [23:0] cpu_address,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_data_o,
  output logic        cpu_stall,
  output logic [23:0] fb_address,
  output logic [31:0] fb_data,
  output logic        fb_write
);

  fill_state_t state, state_next;

  logic [4:0]  pos_x;
  logic [9:0]  pos_y;
  logic [5:0]  size_w;
  logic [9:0]  size_h;
  logic [31:0] pattern;
  logic        err;
  logic        inv;

  logic        is_reg;
  logic [1:0]  reg_sel;
  logic        busy;
  logic        ctrl_read;
  logic        start_req;
  logic        bounds_ok;
  logic        start_fill;
  logic        advance;
  logic [6:0]  x_end;
  logic [10:0] y_end;
  logic [31:0] status;
  logic [31:0] reg_rdata;
  logic [13:0] word_index;
  logic        last;
  logic        row_odd;

  assign is_reg    = (cpu_address >= REG_BASE) && (cpu_address <= REG_BASE + 24'd12);
  assign reg_sel   = cpu_address[3:2] - REG_BASE[3:2];
  assign busy      = (state == ST_FILL);
  assign ctrl_read = cpu_read && is_reg && (reg_sel == REG_CTRL);
  assign start_req = !busy && cpu_write && is_reg && (reg_sel == REG_CTRL)
                     && cpu_data_i[CTRL_START_BIT];

  assign x_end      = {2'b0, pos_x} + {1'b0, size_w};
  assign y_end      = {1'b0, pos_y} + {1'b0, size_h};
  assign bounds_ok  = (size_w != 6'd0) && (size_h != 10'd0)
                      && (x_end <= 7'(ROW_WORDS)) && (y_end <= 11'(ROWS));
  assign start_fill = start_req && bounds_ok;

  assign status = {30'b0, err, busy};

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_POS:     reg_rdata = {6'b0, pos_y, 11'b0, pos_x};
      REG_SIZE:    reg_rdata = {6'b0, size_h, 10'b0, size_w};
      REG_PATTERN: reg_rdata = pattern;
      default:     reg_rdata = status;
    endcase
  end

  gpu_fill_addr_gen u_addr_gen (
    .clk_bus    (clk_bus),
    .rst        (rst),
    .start      (start_fill),
    .advance    (advance),
    .x          (pos_x),
    .y          (pos_y),
    .w          (size_w),
    .h          (size_h),
    .word_index (word_index),
    .last       (last),
    .row_odd    (row_odd)
  );

  always_ff @(posedge clk_bus) begin
    if (rst) begin
      state   <= ST_IDLE;
      pos_x   <= '0;
      pos_y   <= '0;
      size_w  <= '0;
      size_h  <= '0;
      pattern <= '0;
      err     <= 1'b0;
      inv     <= 1'b0;
    end else begin
      state <= state_next;
      // Registers only change in IDLE; writes during a fill are stalled.
      if (!busy && cpu_write && is_reg) begin
        case (reg_sel)
          REG_POS: begin
            pos_x <= cpu_data_i[4:0];
            pos_y <= cpu_data_i[25:16];
          end
          REG_SIZE: begin
            size_w <= cpu_data_i[5:0];
            size_h <= cpu_data_i[25:16];
          end
          REG_PATTERN: pattern <= cpu_data_i;
          default: begin
            if (cpu_data_i[CTRL_START_BIT]) begin
              err <= !bounds_ok;
`ifdef FILL_ROWINV_EN
              inv <= cpu_data_i[CTRL_INV_BIT];
`else
              inv <= 1'b0;
`endif
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    fb_address = cpu_address;
    fb_data    = cpu_data_i;
    fb_write   = 1'b0;
    cpu_stall  = 1'b0;
    cpu_data_o = '0;
    advance    = 1'b0;
    case (state)
      ST_IDLE: begin
        fb_write = cpu_write && !is_reg;
        if (cpu_read && is_reg) cpu_data_o = reg_rdata;
        if (start_fill) state_next = ST_FILL;
      end
      ST_FILL: begin
        fb_write   = 1'b1;
        fb_address = {8'd0, word_index, 2'b00};
        fb_data    = (inv && row_odd) ? ~pattern : pattern;
        advance    = 1'b1;
        cpu_stall  = (cpu_read || cpu_write) && !ctrl_read;
        if (ctrl_read) cpu_data_o = status;
        if (last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Reset kills bus activity in the same cycle it is raised.
    if (rst) begin
      fb_write   = 1'b0;
      cpu_stall  = 1'b0;
      cpu_data_o = '0;
    end
  end

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Scoreboard bench for gpu_fill_engine: expected framebuffer writes are queued
// by a rectangle model and popped by a monitor on every fb_write.
module tb_gpu_fill_engine;

  localparam logic [23:0] RB       = 24'h50010;
  localparam logic [23:0] A_POS    = RB;
  localparam logic [23:0] A_SIZE   = RB + 24'd4;
  localparam logic [23:0] A_PAT    = RB + 24'd8;
  localparam logic [23:0] A_CTRL   = RB + 24'd12;
  localparam int          BOUND    = 20000;

  logic        clk_bus = 1'b0;
  logic        rst;
  logic [23:0] cpu_address;
  logic [31:0] cpu_data_i;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_data_o;
  logic        cpu_stall;
  logic [23:0] fb_address;
  logic [31:0] fb_data;
  logic        fb_write;

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          wr_count = 0;
  logic [23:0] last_addr = '0;
  logic [23:0] prev_addr = '0;
  logic        model_err = 1'b0;

  gpu_fill_engine dut (
    .clk_bus     (clk_bus),
    .rst         (rst),
    .cpu_address (cpu_address),
    .cpu_data_i  (cpu_data_i),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall   (cpu_stall),
    .fb_address  (fb_address),
    .fb_data     (fb_data),
    .fb_write    (fb_write)
  );

  always #5 clk_bus = ~clk_bus;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every framebuffer write must match the head of the queue.
  always @(negedge clk_bus) begin
    if (fb_write !== 1'b0) begin
      wr_t e;
      wr_count++;
      prev_addr = last_addr;
      last_addr = fb_address;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr 0x%06h data 0x%08h, expected none",
                 fb_address, fb_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("fb_address", {8'b0, fb_address}, {8'b0, e.addr});
        checkOutput("fb_data", fb_data, e.data);
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [23:0] a, input logic [31:0] d);
    cpu_read    = rd;
    cpu_write   = wr;
    cpu_address = a;
    cpu_data_i  = d;
  endtask

  task automatic idleBus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_bus); #1;
      drive(1'b0, 1'b0, 24'h0, 32'h0);
    end
  endtask

  // Issues one write, holding it while stalled; pass-through writes are expected on fb_*.
  task automatic applyStimulus(input logic [23:0] a, input logic [31:0] d, output int stalled);
    wr_t e;
    stalled = 0;
    if (!(a >= RB && a <= RB + 24'd12)) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk_bus); #1;
    drive(1'b0, 1'b1, a, d);
    @(negedge clk_bus);
    while (cpu_stall === 1'b1 && stalled < BOUND) begin
      stalled++;
      @(posedge clk_bus); #1;
      @(negedge clk_bus);
    end
    if (stalled >= BOUND) begin
      tests++;
      fails++;
      $display("[TB] FAIL write_timeout: got stall after %0d cycles, expected release", stalled);
    end
  endtask

  task automatic regRead(input logic [23:0] a, output logic [31:0] d, output logic st);
    @(posedge clk_bus); #1;
    drive(1'b1, 1'b0, a, 32'h0);
    @(negedge clk_bus);
    d  = cpu_data_o;
    st = cpu_stall;
  endtask

  // Polls CTRL every cycle, counting busy cycles until the engine is idle.
  task automatic waitIdle(output int busy_cycles, output logic [31:0] st_word);
    logic done;
    done = 1'b0;
    busy_cycles = 0;
    st_word = '0;
    for (int i = 0; i < BOUND && !done; i++) begin
      @(posedge clk_bus); #1;
      drive(1'b1, 1'b0, A_CTRL, 32'h0);
      @(negedge clk_bus);
      checkOutput("poll_stall", {31'b0, cpu_stall}, 32'h0);
      if (cpu_data_o[0] === 1'b1) busy_cycles++;
      else begin
        st_word = cpu_data_o;
        done = 1'b1;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL busy_timeout: got busy after %0d cycles, expected idle", BOUND);
    end
  endtask

  // Reference model: legality check and row-major expected word stream.
  task automatic modelFill(input int x, input int y, input int w, input int h,
                           input bit inv, input logic [31:0] pat, output bit legal);
    wr_t e;
    bit  flip;
    legal = (w != 0) && (h != 0) && (x + w <= 25) && (y + h <= 600);
    model_err = !legal;
    if (legal) begin
      for (int r = 0; r < h; r++) begin
`ifdef FILL_ROWINV_EN
        flip = inv && (((y + r) % 2) == 1);
`else
        flip = 1'b0 & inv;
`endif
        for (int c = 0; c < w; c++) begin
          e.addr = 24'(((y + r) * 25 + x + c) * 4);
          e.data = flip ? ~pat : pat;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic setupRegs(input int x, input int y, input int w, input int h, input logic [31:0] pat);
    int s;
    applyStimulus(A_POS, {6'b0, 10'(y), 11'b0, 5'(x)}, s);
    applyStimulus(A_SIZE, {6'b0, 10'(h), 10'b0, 6'(w)}, s);
    applyStimulus(A_PAT, pat, s);
  endtask

  task automatic runFill(input string name, input int x, input int y, input int w, input int h,
                         input bit inv, input logic [31:0] pat);
    bit          legal;
    int          s;
    int          bc;
    logic [31:0] st;
    setupRegs(x, y, w, h, pat);
    modelFill(x, y, w, h, inv, pat, legal);
    applyStimulus(A_CTRL, {30'b0, inv, 1'b1}, s);
    waitIdle(bc, st);
    idleBus(1);
    checkOutput({name, "_busy_cycles"}, bc, legal ? w * h : 0);
    checkOutput({name, "_status"}, st, {30'b0, model_err, 1'b0});
    checkOutput({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] d;
    logic        st;
    int          s;
    int          bc;
    int          base;
    bit          legal;
    bit          hit;

    rst = 1'b1;
    drive(1'b1, 1'b0, A_CTRL, 32'h0);
    repeat (3) @(posedge clk_bus);
    @(negedge clk_bus);
    checkOutput("reset_fb_write", {31'b0, fb_write}, 32'h0);
    checkOutput("reset_stall", {31'b0, cpu_stall}, 32'h0);
    checkOutput("reset_data_o", cpu_data_o, 32'h0);
    @(posedge clk_bus); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 24'h0, 32'h0);

    regRead(A_POS, d, st);   checkOutput("reset_pos", d, 32'h0);
    regRead(A_SIZE, d, st);  checkOutput("reset_size", d, 32'h0);
    regRead(A_PAT, d, st);   checkOutput("reset_pattern", d, 32'h0);
    regRead(A_CTRL, d, st);  checkOutput("reset_status", d, 32'h0);

    applyStimulus(24'h000010, 32'hDEADBEEF, s);
    for (int i = 0; i < 6; i++)
      applyStimulus(24'($urandom_range(0, 32'h4FFFF)) & 24'hFFFFFC, $urandom, s);
    idleBus(1);

    setupRegs(7, 100, 3, 4, 32'h12345678);
    regRead(A_POS, d, st);   checkOutput("readback_pos", d, {6'b0, 10'd100, 11'b0, 5'd7});
    regRead(A_SIZE, d, st);  checkOutput("readback_size", d, {6'b0, 10'd4, 10'b0, 6'd3});
    regRead(A_PAT, d, st);   checkOutput("readback_pattern", d, 32'h12345678);

    runFill("basic", 2, 3, 2, 2, 1'b0, 32'hA5A5A5A5);
    runFill("bounds_err", 20, 3, 6, 2, 1'b0, 32'h11111111);
    runFill("zero_w", 0, 0, 0, 2, 1'b0, 32'h22222222);
    runFill("y_over", 0, 599, 1, 2, 1'b0, 32'h33333333);
    runFill("clear_err", 24, 599, 1, 1, 1'b0, 32'h44444444);
    runFill("rowinv", 0, 1, 1, 2, 1'b1, 32'h0000FFFF);

    for (int i = 0; i < 10; i++)
      runFill("random", $urandom_range(0, 25), $urandom_range(0, 599), $urandom_range(0, 7),
              $urandom_range(0, 5), 1'($urandom), $urandom);

    // Full screen with a CPU write that must wait for the fill to finish.
    setupRegs(0, 0, 25, 600, 32'hC3C3C3C3);
    modelFill(0, 0, 25, 600, 1'b0, 32'hC3C3C3C3, legal);
    base = wr_count;
    applyStimulus(A_CTRL, 32'h1, s);
    idleBus(100);
    applyStimulus(24'h000100, 32'hCAFEF00D, s);
    checkOutput("midfill_stalled", {31'b0, s > 0}, 32'h1);
    regRead(A_CTRL, d, st);
    checkOutput("full_status", d, 32'h0);
    checkOutput("full_write_count", wr_count - base, 15001);
    checkOutput("full_last_addr", {8'b0, prev_addr}, 32'h0000EA5C);
    checkOutput("full_drained", exp_q.size(), 0);
    idleBus(1);

    // Reset after ten writes of a fill; polling must show busy without stalling.
    setupRegs(0, 0, 25, 10, 32'h5A5A5A5A);
    modelFill(0, 0, 25, 10, 1'b0, 32'h5A5A5A5A, legal);
    base = wr_count;
    applyStimulus(A_CTRL, 32'h1, s);
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(posedge clk_bus); #1;
      if (wr_count - base >= 10) begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 24'h0, 32'h0);
        exp_q.delete();
        model_err = 1'b0;
        hit = 1'b1;
      end else begin
        drive(1'b1, 1'b0, A_CTRL, 32'h0);
        @(negedge clk_bus);
        checkOutput("poll_busy", cpu_data_o, 32'h1);
        checkOutput("poll_no_stall", {31'b0, cpu_stall}, 32'h0);
      end
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("[TB] FAIL reset_wait: got %0d writes, expected 10", wr_count - base);
    end
    repeat (3) @(posedge clk_bus);
    #1 rst = 1'b0;
    idleBus(3);
    checkOutput("reset_write_count", wr_count - base, 10);
    regRead(A_CTRL, d, st);  checkOutput("post_reset_status", d, 32'h0);
    regRead(A_POS, d, st);   checkOutput("post_reset_pos", d, 32'h0);
    regRead(A_SIZE, d, st);  checkOutput("post_reset_size", d, 32'h0);
    regRead(A_PAT, d, st);   checkOutput("post_reset_pattern", d, 32'h0);

    runFill("after_reset", 5, 10, 4, 3, 1'b1, 32'hF0F0F0F0);
    idleBus(2);
    checkOutput("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
